// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one imem read per PC, buffers {inst, pc} in a
// small FIFO toward decode, and holds the PC until each fetch is granted.
module inst_fetch #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        redirect,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [31:0]      req_pc;
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             fire;
  logic             push;
  logic             pop;

  // Next-state and request/handshake decode; request is suppressed while in reset.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    push      = 1'b0;
    case (state)
      ST_REQ: begin
        imem_req = rst_n & (count < CNT_W'(DEPTH)) & ~redirect;
        if (imem_req && imem_gnt) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          push      = ~redirect;
          state_nxt = ST_REQ;
        end else if (redirect) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_comb begin
    fire      = imem_req & imem_gnt;
    pc_hold   = ~fire;
    imem_addr = pc;
    id_valid  = (count != '0);
    pop       = id_valid & id_ready;
    id_inst   = id_valid ? inst_q[rd_ptr] : 32'h0;
    id_pc     = id_valid ? pc_q[rd_ptr]   : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_REQ;
      req_pc <= 32'h0;
    end else begin
      state <= state_nxt;
      if (fire) req_pc <= pc;
    end
  end

  // Redirect flushes the buffer regardless of any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= req_pc;
    end
  end

endmodule
